// File: rtl/button_conditioner_if.sv
// ---------------------------------------------------------------------------
// button_conditioner_if
//
// Bundles the five push-button signals exchanged between the board-side
// source (raw buttons in, conditioned outputs observed) and the
// button_conditioner block.
//
// Signals (bit 0 Up, 1 Down, 2 Left, 3 Right, 4 Centre; 1 = pressed):
//   Bt_Raw    raw asynchronous buttons, driven by the board side
//   Bt_Level  debounced level per button, driven by the conditioner
//   Bt_Press  one-cycle press pulse per button, driven by the conditioner
//
// Modports:
//   master  board side / consumer: drives Bt_Raw, observes the outputs
//   slave   button_conditioner: samples Bt_Raw, drives Bt_Level/Bt_Press
// ---------------------------------------------------------------------------
interface button_conditioner_if;

    logic [4:0] Bt_Raw;
    logic [4:0] Bt_Level;
    logic [4:0] Bt_Press;

    modport master (
        output Bt_Raw,
        input  Bt_Level,
        input  Bt_Press
    );

    modport slave (
        input  Bt_Raw,
        output Bt_Level,
        output Bt_Press
    );

endinterface

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//
// Front-end stage for the five board push-buttons. Each raw button is
// synchronised to sysclk through two flops, debounced by its own stability
// counter, and presented as a clean level plus a one-cycle press pulse.
// Buttons are fully independent; several press bits may be high together.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive cycles the synchronised input must differ
//                    from the current level before the level flips (>= 2)
//   REPEAT_DELAY     cycles from a press pulse to the first auto-repeat pulse
//   REPEAT_PERIOD    cycles between subsequent auto-repeat pulses
//
// Ports:
//   sysclk  in   system clock, all logic on its rising edge
//   reset   in   synchronous, active-high reset
//   btn     slave modport of button_conditioner_if
//             Bt_Raw   in   raw buttons (asynchronous)
//             Bt_Level out  debounced levels
//             Bt_Press out  registered one-cycle press pulses
//
// Optional feature (compile-time macro BTN_AUTOREPEAT_EN):
//   When defined, Up/Down/Left/Right (bits 0-3) emit extra single-cycle
//   press pulses while held: the first REPEAT_DELAY cycles after the press
//   pulse, then every REPEAT_PERIOD cycles. Centre (bit 4) never repeats.
//   When undefined, no repeat logic is built and each debounced press gives
//   exactly one pulse.
// ---------------------------------------------------------------------------
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input logic                 sysclk,
    input logic                 reset,
    button_conditioner_if.slave btn
);

    localparam int N_BTN = 5;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Elaboration-time guards on the configuration.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("button_conditioner: DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("button_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
    end

    // -----------------------------------------------------------------------
    // Synchroniser: two flops per bit; only s2 feeds the debounce logic.
    // -----------------------------------------------------------------------
    logic [N_BTN-1:0] s1;
    logic [N_BTN-1:0] s2;

    always_ff @(posedge sysclk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its source; blocking here would let
        // s2 see the new s1 and collapse the two stages into one.
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn.Bt_Raw;
            s2 <= s1;
        end
    end

    // -----------------------------------------------------------------------
    // Debounce: per-bit stability counter and level.
    // -----------------------------------------------------------------------
    logic [N_BTN-1:0] level_q;
    logic [N_BTN-1:0] level_d;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];
    logic [N_BTN-1:0] flip;       // level toggles at this edge
    logic [N_BTN-1:0] rise;       // level goes 0 -> 1 at this edge
    logic [N_BTN-1:0] press_q;
    logic [N_BTN-1:0] press_d;

    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional assignment; a path that leaves a signal unassigned
        // would otherwise infer a latch.
        level_d = level_q;
        flip    = '0;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = '0;
            if (s2[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    // Input has differed for DEBOUNCE_CYCLES cycles in a row.
                    flip[i]    = 1'b1;
                    level_d[i] = ~level_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
            // s2 matching the level leaves cnt_d at 0, so any glitch shorter
            // than DEBOUNCE_CYCLES restarts the count.
        end
        rise = flip & ~level_q;
    end

`ifdef BTN_AUTOREPEAT_EN
    // -----------------------------------------------------------------------
    // Auto-repeat for the four direction buttons (bits 0-3).
    // Per bit: IDLE while released, DELAY until the first repeat, then
    // PERIOD for every later repeat. The counter clears on the press pulse
    // and on every repeat pulse.
    // -----------------------------------------------------------------------
    localparam int N_RPT   = 4;
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_PERIOD
    } rpt_state_t;

    rpt_state_t       rpt_state_q [N_RPT];
    rpt_state_t       rpt_state_d [N_RPT];
    logic [RPT_W-1:0] rpt_cnt_q   [N_RPT];
    logic [RPT_W-1:0] rpt_cnt_d   [N_RPT];
    logic [N_RPT-1:0] rpt_pulse;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            for (int i = 0; i < N_RPT; i++) begin
                rpt_state_q[i] <= RPT_IDLE;
                rpt_cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_RPT; i++) begin
                rpt_state_q[i] <= rpt_state_d[i];
                rpt_cnt_q[i]   <= rpt_cnt_d[i];
            end
        end
    end

    always_comb begin
        rpt_pulse = '0;
        for (int i = 0; i < N_RPT; i++) begin
            rpt_state_d[i] = rpt_state_q[i];
            rpt_cnt_d[i]   = rpt_cnt_q[i];
            if (rise[i]) begin
                // Fresh press: the press pulse itself is emitted by the
                // debounce path; start timing the first repeat from here.
                rpt_state_d[i] = RPT_DELAY;
                rpt_cnt_d[i]   = '0;
            end else if (!level_q[i] || flip[i]) begin
                // Released, or being released on this very edge: stop at
                // once and never pulse on the release edge.
                rpt_state_d[i] = RPT_IDLE;
                rpt_cnt_d[i]   = '0;
            end else begin
                unique case (rpt_state_q[i])
                    RPT_DELAY: begin
                        if (rpt_cnt_q[i] == DELAY_LAST) begin
                            rpt_pulse[i]   = 1'b1;
                            rpt_cnt_d[i]   = '0;
                            rpt_state_d[i] = RPT_PERIOD;
                        end else begin
                            rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
                        end
                    end
                    RPT_PERIOD: begin
                        if (rpt_cnt_q[i] == PERIOD_LAST) begin
                            rpt_pulse[i] = 1'b1;
                            rpt_cnt_d[i] = '0;
                        end else begin
                            rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        // Held level without a recorded press (cannot occur
                        // after reset); stay idle rather than repeat.
                        rpt_state_d[i] = RPT_IDLE;
                        rpt_cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Centre (bit 4) only ever gets the initial press pulse.
    assign press_d = rise | {1'b0, rpt_pulse};
`else
    assign press_d = rise;
`endif

    // -----------------------------------------------------------------------
    // Debounce state and registered outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge sysclk) begin
        if (reset) begin
            level_q <= '0;
            press_q <= '0;
            // NOTE: the counters are a handful of flops, not a RAM, so
            // clearing the whole array in reset is cheap and required for a
            // mid-count reset to restart debouncing cleanly.
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            level_q <= level_d;
            press_q <= press_d;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn.Bt_Level = level_q;
    assign btn.Bt_Press = press_q;

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
//
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3. A vector table covers clean presses,
// releases, simultaneous buttons and a short glitch; hand-written
// sequences cover bounce, reset mid-count and held-button repetition.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int DEB = 4;

    logic sysclk = 1'b0;
    logic reset;

    button_conditioner_if bif ();

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .btn    (bif)
    );

    always #5 sysclk = ~sysclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    // One table record: drive raw, advance 'edges' rising edges, then compare.
    typedef struct packed {
        logic [4:0] raw;
        logic [7:0] edges;
        logic [4:0] exp_level;
        logic [4:0] exp_press;
    } vec_t;

    localparam int N_VEC = 14;
    vec_t vecs [N_VEC];

    // Hold one button, capture its pulse pattern over offsets 0..30 from the
    // press pulse, then release and confirm no pulse on or after release.
    task automatic hold_test(input int bit_idx, input logic [30:0] exp_mask, input string tag);
        logic [30:0] mask;
        logic        found;
        int          extra;
        bif.Bt_Raw          = '0;
        bif.Bt_Raw[bit_idx] = 1'b1;
        found = 1'b0;
        for (int e = 0; e < 10 && !found; e++) begin
            step();
            if (bif.Bt_Press[bit_idx]) found = 1'b1;
        end
        check({tag, "_press_seen"}, 32'(found), 32'd1);
        mask    = '0;
        mask[0] = found;
        for (int o = 1; o <= 30; o++) begin
            step();
            mask[o] = bif.Bt_Press[bit_idx];
        end
        check({tag, "_pulse_mask"}, 32'(mask), 32'(exp_mask));
        bif.Bt_Raw = '0;
        found = 1'b0;
        extra = 0;
        for (int e = 0; e < 10 && !found; e++) begin
            step();
            if (!bif.Bt_Level[bit_idx]) begin
                found = 1'b1;
                if (bif.Bt_Press[bit_idx]) extra++;
            end
        end
        check({tag, "_level_fell"}, 32'(found), 32'd1);
        for (int e = 0; e < 6; e++) begin
            step();
            if (bif.Bt_Press[bit_idx]) extra++;
        end
        check({tag, "_no_pulse_after_release"}, 32'(extra), 32'd0);
    endtask

    initial begin
        logic [30:0] rpt_mask;
        int          press_cnt;
        int          press_at;
        int          early;

        // Level/press appear on the 6th edge after raw changes (DEB+2).
        vecs[0]  = '{5'b00001, 8'd5, 5'b00000, 5'b00000};
        vecs[1]  = '{5'b00001, 8'd1, 5'b00001, 5'b00001};
        vecs[2]  = '{5'b00001, 8'd1, 5'b00001, 5'b00000};
        vecs[3]  = '{5'b00000, 8'd5, 5'b00001, 5'b00000};
        vecs[4]  = '{5'b00000, 8'd1, 5'b00000, 5'b00000};
        vecs[5]  = '{5'b10001, 8'd6, 5'b10001, 5'b10001};
        vecs[6]  = '{5'b10001, 8'd1, 5'b10001, 5'b00000};
        vecs[7]  = '{5'b00000, 8'd6, 5'b00000, 5'b00000};
        // 3-cycle glitch on Left: s2 differs 3 cycles, counter never flips.
        vecs[8]  = '{5'b00100, 8'd3, 5'b00000, 5'b00000};
        vecs[9]  = '{5'b00000, 8'd3, 5'b00000, 5'b00000};
        vecs[10] = '{5'b00000, 8'd3, 5'b00000, 5'b00000};
        vecs[11] = '{5'b01000, 8'd5, 5'b00000, 5'b00000};
        vecs[12] = '{5'b01000, 8'd1, 5'b01000, 5'b01000};
        vecs[13] = '{5'b00000, 8'd7, 5'b00000, 5'b00000};

        bif.Bt_Raw = '0;
        reset      = 1'b1;
        repeat (2) step();
        check("reset_level", 32'(bif.Bt_Level), 32'd0);
        check("reset_press", 32'(bif.Bt_Press), 32'd0);
        reset = 1'b0;

        for (int v = 0; v < N_VEC; v++) begin
            bif.Bt_Raw = vecs[v].raw;
            repeat (int'(vecs[v].edges)) step();
            check($sformatf("vec%0d_level", v), 32'(bif.Bt_Level), 32'(vecs[v].exp_level));
            check($sformatf("vec%0d_press", v), 32'(bif.Bt_Press), 32'(vecs[v].exp_press));
        end

        // Bounce on Right: high 3, low 1, then high. The final stable high is
        // first sampled at edge 5, so the single press lands on edge 10.
        press_cnt = 0;
        press_at  = 0;
        early     = 0;
        for (int e = 1; e <= 19; e++) begin
            bif.Bt_Raw = (e == 4) ? 5'b00000 : 5'b01000;
            step();
            if (bif.Bt_Press[3]) begin
                press_cnt++;
                press_at = e;
            end
            if (e < 10 && bif.Bt_Level[3]) early++;
        end
        check("bounce_early_level", 32'(early), 32'd0);
        check("bounce_press_count", 32'(press_cnt), 32'd1);
        check("bounce_press_edge", 32'(press_at), 32'd10);
        check("bounce_level_held", 32'(bif.Bt_Level), 32'b01000);
        bif.Bt_Raw = '0;
        repeat (7) step();
        check("bounce_released", 32'(bif.Bt_Level), 32'd0);

        // Reset mid-count: Centre already pressed, Down counter at 2.
        bif.Bt_Raw = 5'b10000;
        repeat (6) step();
        check("rst_pre_level", 32'(bif.Bt_Level), 32'b10000);
        bif.Bt_Raw = 5'b10010;
        repeat (4) step();
        reset = 1'b1;
        step();
        check("rst_mid_level", 32'(bif.Bt_Level), 32'd0);
        check("rst_mid_press", 32'(bif.Bt_Press), 32'd0);
        reset = 1'b0;
        early = 0;
        for (int e = 1; e <= 5; e++) begin
            step();
            if (bif.Bt_Press != 5'b0 || bif.Bt_Level != 5'b0) early++;
        end
        check("rst_no_early_output", 32'(early), 32'd0);
        step();
        check("rst_repress_press", 32'(bif.Bt_Press), 32'b10010);
        check("rst_repress_level", 32'(bif.Bt_Level), 32'b10010);
        step();
        check("rst_repress_width", 32'(bif.Bt_Press), 32'd0);
        bif.Bt_Raw = '0;
        repeat (7) step();
        check("rst_released", 32'(bif.Bt_Level), 32'd0);

        // Held Left: repeats at +10, then every 3 cycles, when enabled.
        rpt_mask = 31'd1;
`ifdef BTN_AUTOREPEAT_EN
        for (int o = 10; o <= 28; o += 3) rpt_mask[o] = 1'b1;
`endif
        hold_test(2, rpt_mask, "hold_left");
        // Held Centre never repeats.
        hold_test(4, 31'd1, "hold_centre");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
